// File: rtl/huff_pkg.sv
// Shared types for the Huffman encoder write path: code/length types and packer states.
package huff_pkg;
   localparam int DEF_MAX_CODE_LEN = 16;

   typedef logic [DEF_MAX_CODE_LEN-1:0]              code_t;
   typedef logic [$clog2(DEF_MAX_CODE_LEN+1)-1:0]    len_t;

   typedef enum logic [1:0] {RUN, FLUSH, PAD, DONE} pack_state_e;
endpackage

// File: rtl/code_packer.sv
// Packs MSB-first variable-length Huffman codes into bytes for the output FIFO.
// Optional CODE_PACKER_STATS_EN adds a saturating written-byte counter (byte_count).
module code_packer
   import huff_pkg::*;
#(
   parameter int MAX_CODE_LEN = DEF_MAX_CODE_LEN,
   parameter int LEN_W        = $clog2(MAX_CODE_LEN+1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [MAX_CODE_LEN-1:0] code,
   input  logic [LEN_W-1:0]        code_len,
   input  logic                    code_valid,
   output logic                    code_ready,
   input  logic                    done,
   input  logic                    full,
   output logic [7:0]              data_out,
   output logic                    w_en,
   output logic                    flushed
`ifdef CODE_PACKER_STATS_EN
   ,
   output logic [31:0]             byte_count
`endif
);

   localparam int ACC_W  = MAX_CODE_LEN + 7;
   localparam int FILL_W = $clog2(ACC_W+1);

   logic [ACC_W-1:0]  acc;
   logic [FILL_W-1:0] fill;
   logic [FILL_W-1:0] fill_next;
   pack_state_e       state;
   logic              done_seen;

   logic [LEN_W-1:0]  len_eff;
   logic              accept;
   logic              emit;
   logic              pad_wr;

   function automatic logic [ACC_W-1:0] mask_code(input logic [MAX_CODE_LEN-1:0] c,
                                                  input logic [LEN_W-1:0] l);
      return ACC_W'(c) & ~({ACC_W{1'b1}} << l);
   endfunction

   assign len_eff    = (code_len > LEN_W'(MAX_CODE_LEN)) ? LEN_W'(MAX_CODE_LEN) : code_len;
   assign code_ready = (state == RUN) & (fill <= FILL_W'(7)) & ~done_seen & ~rst;
   assign accept     = code_valid & code_ready;
   // rst gating keeps stale buffered bits from reaching the FIFO during a synchronous reset
   assign emit       = (fill >= FILL_W'(8)) & ~full & (state != DONE) & ~rst;
   assign pad_wr     = (state == PAD) & ~full & ~rst;
   assign w_en       = emit | pad_wr;
   assign flushed    = (state == DONE) & ~rst;

   assign fill_next  = fill - (emit ? FILL_W'(8) : '0) + (accept ? FILL_W'(len_eff) : '0);

   always_comb begin
      data_out = '0;
      if (emit)
         data_out = 8'(acc >> (fill - FILL_W'(8)));
      else if (pad_wr)
         data_out = 8'(acc << (FILL_W'(8) - fill));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc       <= '0;
         fill      <= '0;
         state     <= RUN;
         done_seen <= 1'b0;
      end else begin
         if (accept)
            acc <= (acc << len_eff) | mask_code(code, len_eff);
         fill <= fill_next;
         case (state)
            RUN: begin
               if (done) begin
                  done_seen <= 1'b1;
                  state     <= FLUSH;
               end
            end
            FLUSH: begin
               if (fill < FILL_W'(8))
                  state <= (fill == '0) ? DONE : PAD;
            end
            PAD: begin
               if (pad_wr) begin
                  fill  <= '0;
                  state <= DONE;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef CODE_PACKER_STATS_EN
   always_ff @(posedge clk) begin
      if (rst)
         byte_count <= '0;
      else if (w_en && byte_count != 32'hFFFF_FFFF)
         byte_count <= byte_count + 32'd1;
   end
`endif

endmodule

// File: tb/tb_code_packer.sv
// Bench for code_packer: directed scenarios plus random streams against a bit-queue model.
module tb_code_packer;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] code = '0;
   logic [4:0]  code_len = '0;
   logic        code_valid = 1'b0;
   logic        code_ready;
   logic        done = 1'b0;
   logic        full = 1'b0;
   logic [7:0]  data_out;
   logic        w_en;
   logic        flushed;
`ifdef CODE_PACKER_STATS_EN
   logic [31:0] byte_count;
`endif

   int   errors = 0;
   int   checks = 0;
   bit   q[$];
   logic [7:0] wr_log[$];
   bit   done_given = 0;
   bit   acc_flag = 0;

   code_packer dut (
      .clk(clk), .rst(rst), .code(code), .code_len(code_len), .code_valid(code_valid),
      .code_ready(code_ready), .done(done), .full(full), .data_out(data_out),
      .w_en(w_en), .flushed(flushed)
`ifdef CODE_PACKER_STATS_EN
      , .byte_count(byte_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // One clock: sample and score at negedge, then let the posedge happen.
   task automatic step();
      logic [7:0] exp_b;
      int n, len;
      @(negedge clk);
      acc_flag = 0;
      if (rst) begin
         check("rst_w_en", w_en, 0);
         check("rst_ready", code_ready, 0);
         check("rst_flushed", flushed, 0);
         check("rst_data", data_out, 0);
         q.delete();
         wr_log.delete();
         done_given = 0;
      end else begin
         if (flushed) check("w_en_after_flush", w_en, 0);
         check("code_ready", code_ready, 32'(!done_given && q.size() <= 7));
         if (full) check("w_en_full", w_en, 0);
         else if (q.size() >= 8) check("w_en_due", w_en, 1);
         else if (!done_given) check("w_en_idle", w_en, 0);
         if (w_en) begin
            n = (q.size() >= 8) ? 8 : q.size();
            check("wr_bits_avail", 32'(n > 0), 1);
            exp_b = '0;
            for (int i = 0; i < n; i++) exp_b[7-i] = q.pop_front();
            check("data_out", data_out, exp_b);
            wr_log.push_back(data_out);
         end else begin
            check("data_idle", data_out, 0);
         end
         if (q.size() > 0 || !done_given) check("flushed_early", flushed, 0);
         if (code_valid && code_ready) begin
            len = (code_len > 16) ? 16 : int'(code_len);
            for (int i = len - 1; i >= 0; i--) q.push_back(code[i]);
            acc_flag = 1;
         end
         if (done) done_given = 1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1; full = 1'b0; code_valid = 1'b0; done = 1'b0;
      repeat (n) step();
      rst = 1'b0;
   endtask

   task automatic send(input logic [15:0] c, input logic [4:0] l, input bit with_done, input bit rnd_full);
      bit got = 0;
      code = c; code_len = l; code_valid = 1'b1; done = with_done;
      for (int k = 0; k < 200 && !got; k++) begin
         if (rnd_full) full = ($urandom_range(0, 3) == 0);
         step();
         done = 1'b0;
         got = acc_flag;
      end
      code_valid = 1'b0;
      check("send_accepted", 32'(got), 1);
   endtask

   task automatic pulse_done();
      done = 1'b1; step(); done = 1'b0;
   endtask

   task automatic wait_flushed(input bit rnd_full);
      for (int k = 0; k < 200 && !flushed; k++) begin
         if (rnd_full) full = ($urandom_range(0, 3) == 0);
         step();
      end
      full = 1'b0;
      check("flushed", flushed, 1);
      check("model_empty", q.size(), 0);
      repeat (3) step();
   endtask

   initial begin
      int nc, l;
      bit use_done;
      logic [31:0] cv;

      // reset held for three cycles
      do_reset(3);

      // 101 + 10011 -> B3
      send(16'h5, 5'd3, 0, 0);
      send(16'h13, 5'd5, 0, 0);
      pulse_done();
      wait_flushed(0);
      check("t2_count", wr_log.size(), 1);
      if (wr_log.size() > 0) check("t2_byte", wr_log[0], 8'hB3);
`ifdef CODE_PACKER_STATS_EN
      check("t2_byte_count", byte_count, 1);
`endif
      pulse_done();
      check("t2_no_extra", wr_log.size(), 1);

      // 110 + 01 -> padded C8
      do_reset(1);
      send(16'h6, 5'd3, 0, 0);
      send(16'h1, 5'd2, 0, 0);
      pulse_done();
      wait_flushed(0);
      check("t3_count", wr_log.size(), 1);
      if (wr_log.size() > 0) check("t3_byte", wr_log[0], 8'hC8);

      // backpressure mid-stream
      do_reset(1);
      send(16'hA, 5'd4, 0, 0);
      send(16'hA, 5'd4, 0, 0);
      full = 1'b1;
      repeat (10) step();
      check("t4_held", wr_log.size(), 0);
      full = 1'b0;
      send(16'hA, 5'd4, 0, 0);
      send(16'hA, 5'd4, 0, 0);
      pulse_done();
      wait_flushed(0);
      check("t4_count", wr_log.size(), 2);
      if (wr_log.size() > 1) begin
         check("t4_b0", wr_log[0], 8'hAA);
         check("t4_b1", wr_log[1], 8'hAA);
      end
`ifdef CODE_PACKER_STATS_EN
      check("t4_byte_count", byte_count, 2);
`endif

      // 16-bit code on top of 7 buffered bits
      do_reset(1);
      send(16'h55, 5'd7, 0, 0);
      send(16'hF00F, 5'd16, 0, 0);
      check("t5_ready_low", code_ready, 0);
      repeat (3) step();
      check("t5_ready_back", code_ready, 1);
      check("t5_count", wr_log.size(), 2);
      if (wr_log.size() > 1) begin
         check("t5_b0", wr_log[0], 8'hAB);
         check("t5_b1", wr_log[1], 8'hE0);
      end
      pulse_done();
      wait_flushed(0);
      if (wr_log.size() > 2) check("t5_pad", wr_log[2], 8'h1E);

      // done together with the last code
      do_reset(1);
      send(16'h5A, 5'd8, 1, 0);
      wait_flushed(0);
      check("t6_count", wr_log.size(), 1);
      if (wr_log.size() > 0) check("t6_byte", wr_log[0], 8'h5A);

      // reset while parked in PAD
      do_reset(1);
      full = 1'b1;
      send(16'h7, 5'd3, 1, 0);
      repeat (5) step();
      do_reset(1);
      step();
      check("t6_no_pad", wr_log.size(), 0);
      check("t6_run_ready", code_ready, 1);
      check("t6_not_flushed", flushed, 0);

      // clamp of oversized code_len
      do_reset(1);
      send(16'hC3A5, 5'd20, 0, 0);
      pulse_done();
      wait_flushed(0);
      check("clamp_count", wr_log.size(), 2);
      if (wr_log.size() > 1) check("clamp_b1", wr_log[1], 8'hA5);

      // random streams with random backpressure
      for (int s = 0; s < 8; s++) begin
         do_reset(1);
         nc = $urandom_range(1, 14);
         for (int c = 0; c < nc; c++) begin
            l = $urandom_range(0, 20);
            cv = $urandom;
            use_done = (c == nc - 1) && (q.size() <= 7) && ($urandom_range(0, 1) == 1);
            send(cv[15:0], 5'(l), use_done, 1);
            if (c == nc - 1 && !use_done) pulse_done();
         end
         wait_flushed(1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
